// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// instruction word width and the default reset PC.
package instr_fetch_unit_pkg;

    localparam int unsigned INSTR_W          = 16;
    localparam int unsigned DEFAULT_RESET_PC = 0;

    typedef enum logic [1:0] {
        IFU_IDLE    = 2'd0,
        IFU_REQ     = 2'd1,
        IFU_DELIVER = 2'd2,
        IFU_ERR     = 2'd3
    } ifu_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory read bus: request/address from the fetch unit,
// data/ready back from memory.
interface instr_fetch_unit_if #(
    parameter int unsigned ADDR_W = 16
);
    import instr_fetch_unit_pkg::*;

    logic               mem_rd_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic [INSTR_W-1:0] mem_rdata;
    logic               mem_ready;

    modport master (
        output mem_rd_req,
        output mem_addr,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_rd_req,
        input  mem_addr,
        output mem_rdata,
        output mem_ready
    );

endinterface

// File: rtl/ifu_wait_timer.sv
// Wait-state counter for the fetch request phase; at_limit flags the last
// permitted wait cycle. MAX_WAIT=0 disables the limit entirely.
module ifu_wait_timer #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic at_limit
);

    localparam int unsigned CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Asserted while the current cycle would be the MAX_WAIT-th unanswered one.
    assign at_limit = (MAX_WAIT != 0) && (32'(count_q) == (MAX_WAIT - 1));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues word reads to instruction memory, tracks PC
// and its successor, buffers branch redirects, and strobes fetched words to the IR.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
    parameter int unsigned       MAX_WAIT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fetch_start,
    input  logic                 redirect_valid,
    input  logic [ADDR_W-1:0]    redirect_pc,
    instr_fetch_unit_if.master   mem,
    output logic [INSTR_W-1:0]   ir_data,
    output logic                 ir_write,
    output logic [ADDR_W-1:0]    pc,
    output logic [ADDR_W-1:0]    pc_next,
    output logic                 fetch_busy,
    output logic                 fetch_err
);

    ifu_state_e         state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  pc_next_q, pc_next_d;
    logic [ADDR_W-1:0]  fetch_addr_q, fetch_addr_d;
    logic [ADDR_W-1:0]  target_q, target_d;
    logic               pending_q, pending_d;
    logic [INSTR_W-1:0] ir_data_q, ir_data_d;
    logic               ir_write_q, ir_write_d;
    logic               mem_rd_req_q, mem_rd_req_d;
    logic               fetch_busy_q, fetch_busy_d;
    logic               fetch_err_q, fetch_err_d;
    logic               timer_clear, timer_en, timer_at_limit;

    ifu_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (timer_clear),
        .enable   (timer_en),
        .at_limit (timer_at_limit)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pc_next_d    = pc_next_q;
        fetch_addr_d = fetch_addr_q;
        target_d     = target_q;
        pending_d    = pending_q;
        ir_data_d    = ir_data_q;
        fetch_err_d  = fetch_err_q;
        timer_clear  = 1'b1;
        timer_en     = 1'b0;

        case (state_q)
            IFU_IDLE: begin
                if (fetch_start) begin
                    if (redirect_valid) begin
                        fetch_addr_d = redirect_pc;
                    end else if (pending_q) begin
                        fetch_addr_d = target_q;
                    end else begin
                        fetch_addr_d = pc_next_q;
                    end
                    pending_d = 1'b0;
                    state_d   = IFU_REQ;
                end else if (redirect_valid) begin
                    target_d  = redirect_pc;
                    pending_d = 1'b1;
                end
            end
            IFU_REQ: begin
                timer_clear = 1'b0;
                if (redirect_valid) begin
                    target_d  = redirect_pc;
                    pending_d = 1'b1;
                end
                if (mem.mem_ready) begin
                    ir_data_d = mem.mem_rdata;
                    pc_d      = fetch_addr_q;
                    pc_next_d = fetch_addr_q + ADDR_W'(1);
                    state_d   = IFU_DELIVER;
                end else begin
                    timer_en = 1'b1;
                    if (timer_at_limit) begin
                        fetch_err_d = 1'b1;
                        state_d     = IFU_ERR;
                    end
                end
            end
            IFU_DELIVER: begin
                if (redirect_valid) begin
                    target_d  = redirect_pc;
                    pending_d = 1'b1;
                end
                state_d = IFU_IDLE;
            end
            IFU_ERR: begin
                state_d = IFU_ERR;
            end
            default: begin
                state_d = IFU_IDLE;
            end
        endcase

        // Output flops follow the next state so every port is registered.
        ir_write_d   = (state_d == IFU_DELIVER);
        mem_rd_req_d = (state_d == IFU_REQ);
        fetch_busy_d = (state_d != IFU_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IFU_IDLE;
            pc_q         <= RESET_PC;
            pc_next_q    <= RESET_PC;
            fetch_addr_q <= '0;
            target_q     <= '0;
            pending_q    <= 1'b0;
            ir_data_q    <= '0;
            ir_write_q   <= 1'b0;
            mem_rd_req_q <= 1'b0;
            fetch_busy_q <= 1'b0;
            fetch_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pc_next_q    <= pc_next_d;
            fetch_addr_q <= fetch_addr_d;
            target_q     <= target_d;
            pending_q    <= pending_d;
            ir_data_q    <= ir_data_d;
            ir_write_q   <= ir_write_d;
            mem_rd_req_q <= mem_rd_req_d;
            fetch_busy_q <= fetch_busy_d;
            fetch_err_q  <= fetch_err_d;
        end
    end

    assign mem.mem_rd_req = mem_rd_req_q;
    assign mem.mem_addr   = fetch_addr_q;
    assign ir_data        = ir_data_q;
    assign ir_write       = ir_write_q;
    assign pc             = pc_q;
    assign pc_next        = pc_next_q;
    assign fetch_busy     = fetch_busy_q;
    assign fetch_err      = fetch_err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a per-cycle vector table for normal
// fetch/redirect flow, plus hand sequences for wait limit, timeout and reset.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_start;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic [15:0] ir_data;
    logic        ir_write;
    logic [15:0] pc;
    logic [15:0] pc_next;
    logic        fetch_busy;
    logic        fetch_err;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    instr_fetch_unit_if #(.ADDR_W(16)) mem_bus ();

    instr_fetch_unit #(
        .ADDR_W   (16),
        .RESET_PC (16'h0000),
        .MAX_WAIT (15)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_start    (fetch_start),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem            (mem_bus),
        .ir_data        (ir_data),
        .ir_write       (ir_write),
        .pc             (pc),
        .pc_next        (pc_next),
        .fetch_busy     (fetch_busy),
        .fetch_err      (fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fs;
        logic        rv;
        logic [15:0] rpc;
        logic        rdy;
        logic [15:0] rdata;
        logic        e_req;
        logic [15:0] e_addr;
        logic        e_irw;
        logic [15:0] e_ird;
        logic [15:0] e_pc;
        logic [15:0] e_pcn;
        logic        e_busy;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic fs, input logic rv, input logic [15:0] rpc,
                       input logic rdy, input logic [15:0] rdata,
                       input logic e_req, input logic [15:0] e_addr, input logic e_irw,
                       input logic [15:0] e_ird, input logic [15:0] e_pc,
                       input logic [15:0] e_pcn, input logic e_busy);
        vec_t v;
        v.fs = fs; v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.rdata = rdata;
        v.e_req = e_req; v.e_addr = e_addr; v.e_irw = e_irw; v.e_ird = e_ird;
        v.e_pc = e_pc; v.e_pcn = e_pcn; v.e_busy = e_busy;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        fetch_start       = 1'b0;
        redirect_valid    = 1'b0;
        redirect_pc       = 16'h0000;
        mem_bus.mem_ready = 1'b0;
        mem_bus.mem_rdata = 16'h0000;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".req"},   32'(mem_bus.mem_rd_req), 32'd0);
        chk({tag, ".addr"},  32'(mem_bus.mem_addr),   32'h0);
        chk({tag, ".irw"},   32'(ir_write),           32'd0);
        chk({tag, ".ird"},   32'(ir_data),            32'h0);
        chk({tag, ".pc"},    32'(pc),                 32'h0);
        chk({tag, ".pcn"},   32'(pc_next),            32'h0);
        chk({tag, ".busy"},  32'(fetch_busy),         32'd0);
        chk({tag, ".err"},   32'(fetch_err),          32'd0);
    endtask

    int unsigned n_req;

    initial begin
        //   fs rv rpc      rdy rdata    | req addr     irw ird      pc       pcn      busy
        add(1, 0, 16'h0000, 0, 16'h0000,   1, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 1);
        add(0, 0, 16'h0000, 1, 16'h8B48,   0, 16'h0000, 1, 16'h8B48, 16'h0000, 16'h0001, 1);
        add(0, 0, 16'h0000, 1, 16'hFFFF,   0, 16'h0000, 0, 16'h8B48, 16'h0000, 16'h0001, 0);
        add(1, 0, 16'h0000, 0, 16'h0000,   1, 16'h0001, 0, 16'h8B48, 16'h0000, 16'h0001, 1);
        add(0, 0, 16'h0000, 0, 16'h0000,   1, 16'h0001, 0, 16'h8B48, 16'h0000, 16'h0001, 1);
        add(0, 0, 16'h0000, 0, 16'h0000,   1, 16'h0001, 0, 16'h8B48, 16'h0000, 16'h0001, 1);
        add(0, 0, 16'h0000, 0, 16'h0000,   1, 16'h0001, 0, 16'h8B48, 16'h0000, 16'h0001, 1);
        add(0, 0, 16'h0000, 1, 16'h2BC9,   0, 16'h0001, 1, 16'h2BC9, 16'h0001, 16'h0002, 1);
        add(0, 0, 16'h0000, 0, 16'h0000,   0, 16'h0001, 0, 16'h2BC9, 16'h0001, 16'h0002, 0);
        add(1, 0, 16'h0000, 0, 16'h0000,   1, 16'h0002, 0, 16'h2BC9, 16'h0001, 16'h0002, 1);
        add(0, 1, 16'h0B78, 0, 16'h0000,   1, 16'h0002, 0, 16'h2BC9, 16'h0001, 16'h0002, 1);
        add(0, 0, 16'h0000, 1, 16'h1234,   0, 16'h0002, 1, 16'h1234, 16'h0002, 16'h0003, 1);
        add(0, 0, 16'h0000, 0, 16'h0000,   0, 16'h0002, 0, 16'h1234, 16'h0002, 16'h0003, 0);
        add(1, 0, 16'h0000, 0, 16'h0000,   1, 16'h0B78, 0, 16'h1234, 16'h0002, 16'h0003, 1);
        add(0, 0, 16'h0000, 1, 16'h5A5A,   0, 16'h0B78, 1, 16'h5A5A, 16'h0B78, 16'h0B79, 1);
        add(0, 0, 16'h0000, 0, 16'h0000,   0, 16'h0B78, 0, 16'h5A5A, 16'h0B78, 16'h0B79, 0);
        add(0, 1, 16'h1111, 0, 16'h0000,   0, 16'h0B78, 0, 16'h5A5A, 16'h0B78, 16'h0B79, 0);
        add(1, 1, 16'hFFFF, 0, 16'h0000,   1, 16'hFFFF, 0, 16'h5A5A, 16'h0B78, 16'h0B79, 1);
        add(0, 0, 16'h0000, 1, 16'hC0DE,   0, 16'hFFFF, 1, 16'hC0DE, 16'hFFFF, 16'h0000, 1);
        add(0, 0, 16'h0000, 0, 16'h0000,   0, 16'hFFFF, 0, 16'hC0DE, 16'hFFFF, 16'h0000, 0);
        add(1, 0, 16'h0000, 0, 16'h0000,   1, 16'h0000, 0, 16'hC0DE, 16'hFFFF, 16'h0000, 1);
        add(1, 1, 16'h3333, 0, 16'h0000,   1, 16'h0000, 0, 16'hC0DE, 16'hFFFF, 16'h0000, 1);
        add(0, 1, 16'h0042, 1, 16'h0001,   0, 16'h0000, 1, 16'h0001, 16'h0000, 16'h0001, 1);
        add(0, 0, 16'h0000, 0, 16'h0000,   0, 16'h0000, 0, 16'h0001, 16'h0000, 16'h0001, 0);
        add(1, 0, 16'h0000, 0, 16'h0000,   1, 16'h0042, 0, 16'h0001, 16'h0000, 16'h0001, 1);
        add(0, 0, 16'h0000, 1, 16'h0002,   0, 16'h0042, 1, 16'h0002, 16'h0042, 16'h0043, 1);
        add(1, 0, 16'h0000, 0, 16'h0000,   0, 16'h0042, 0, 16'h0002, 16'h0042, 16'h0043, 0);
        add(0, 0, 16'h0000, 0, 16'h0000,   0, 16'h0042, 0, 16'h0002, 16'h0042, 16'h0043, 0);

        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk_reset_vals("reset");

        foreach (vq[i]) begin
            fetch_start       = vq[i].fs;
            redirect_valid    = vq[i].rv;
            redirect_pc       = vq[i].rpc;
            mem_bus.mem_ready = vq[i].rdy;
            mem_bus.mem_rdata = vq[i].rdata;
            step();
            chk($sformatf("v%0d.req", i),  32'(mem_bus.mem_rd_req), 32'(vq[i].e_req));
            chk($sformatf("v%0d.addr", i), 32'(mem_bus.mem_addr),   32'(vq[i].e_addr));
            chk($sformatf("v%0d.irw", i),  32'(ir_write),           32'(vq[i].e_irw));
            chk($sformatf("v%0d.ird", i),  32'(ir_data),            32'(vq[i].e_ird));
            chk($sformatf("v%0d.pc", i),   32'(pc),                 32'(vq[i].e_pc));
            chk($sformatf("v%0d.pcn", i),  32'(pc_next),            32'(vq[i].e_pcn));
            chk($sformatf("v%0d.busy", i), 32'(fetch_busy),         32'(vq[i].e_busy));
            chk($sformatf("v%0d.err", i),  32'(fetch_err),          32'd0);
        end
        idle_inputs();

        // Ready arriving in the 15th REQ cycle is still accepted.
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        chk("lim.req1", 32'(mem_bus.mem_rd_req), 32'd1);
        chk("lim.addr", 32'(mem_bus.mem_addr),   32'h0043);
        n_req = 1;
        for (int i = 0; i < 14; i++) begin
            step();
            if (mem_bus.mem_rd_req) n_req++;
        end
        chk("lim.reqcycles", n_req, 32'd15);
        mem_bus.mem_ready = 1'b1;
        mem_bus.mem_rdata = 16'h7777;
        step();
        idle_inputs();
        chk("lim.irw", 32'(ir_write),  32'd1);
        chk("lim.ird", 32'(ir_data),   32'h7777);
        chk("lim.pc",  32'(pc),        32'h0043);
        chk("lim.pcn", 32'(pc_next),   32'h0044);
        chk("lim.err", 32'(fetch_err), 32'd0);
        step();

        // Timeout: memory never answers.
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        n_req = 0;
        for (int i = 0; i < 40 && mem_bus.mem_rd_req; i++) begin
            n_req++;
            step();
        end
        chk("to.reqcycles", n_req,                   32'd15);
        chk("to.req",       32'(mem_bus.mem_rd_req), 32'd0);
        chk("to.err",       32'(fetch_err),          32'd1);
        chk("to.busy",      32'(fetch_busy),         32'd1);
        fetch_start       = 1'b1;
        redirect_valid    = 1'b1;
        redirect_pc       = 16'h0100;
        mem_bus.mem_ready = 1'b1;
        mem_bus.mem_rdata = 16'hDEAD;
        n_req = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (mem_bus.mem_rd_req || ir_write) n_req++;
        end
        idle_inputs();
        chk("err.noactivity", n_req,           32'd0);
        chk("err.sticky",     32'(fetch_err),  32'd1);
        chk("err.ird",        32'(ir_data),    32'h7777);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_vals("err.rst");

        // Reset during the second REQ cycle aborts the fetch.
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        chk("ab.req1", 32'(mem_bus.mem_rd_req), 32'd1);
        step();
        chk("ab.req2", 32'(mem_bus.mem_rd_req), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_vals("ab.rst");
        mem_bus.mem_ready = 1'b1;
        mem_bus.mem_rdata = 16'hBEEF;
        step();
        idle_inputs();
        chk("ab.irw",  32'(ir_write),           32'd0);
        chk("ab.ird",  32'(ir_data),            32'h0);
        chk("ab.req",  32'(mem_bus.mem_rd_req), 32'd0);
        chk("ab.busy", 32'(fetch_busy),         32'd0);
        step();
        chk("ab.irw2", 32'(ir_write),           32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
